// File: rtl/blink_pkg.sv
// Shared types and default timing constants for the blink receive path.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } blink_state_t;

    localparam int CLK_HZ            = 50_000_000;
    localparam int DEF_HALF_PERIOD   = CLK_HZ / 2;
    localparam int DEF_TOL           = 250_000;
    localparam int DEF_FILTER_CYCLES = 16;
    localparam int DEF_LOCK_COUNT    = 3;
    localparam int DEF_TIMEOUT       = CLK_HZ;
    localparam int DEF_CNT_W         = 27;

endpackage

// File: rtl/blink_in_filter.sv
// Two-flop synchronizer plus stability filter; blink_level only follows the
// input after it has held a new value for FILTER_CYCLES consecutive cycles.
module blink_in_filter #(
    parameter int FILTER_CYCLES = blink_pkg::DEF_FILTER_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic blink_in,
    output logic blink_level
);

    localparam int SW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [SW-1:0] STAB_LAST = SW'(FILTER_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [SW-1:0] stab_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta        <= 1'b0;
            sync        <= 1'b0;
            stab_cnt    <= '0;
            blink_level <= 1'b0;
        end else begin
            meta <= blink_in;
            sync <= meta;
            // any cycle agreeing with the current level restarts the qualification
            if (sync == blink_level) begin
                stab_cnt <= '0;
            end else if (stab_cnt == STAB_LAST) begin
                blink_level <= sync;
                stab_cnt    <= '0;
            end else begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/blink_detector.sv
// Measures the interval between filtered toggles of blink_in, checks it against
// the expected half-period and tracks lock / loss-of-activity.
module blink_detector
    import blink_pkg::*;
#(
    parameter int HALF_PERIOD   = DEF_HALF_PERIOD,
    parameter int TOL           = DEF_TOL,
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int LOCK_COUNT    = DEF_LOCK_COUNT,
    parameter int TIMEOUT       = DEF_TIMEOUT,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blink_in,
    output logic             blink_level,
    output logic [CNT_W-1:0] half_period,
    output logic             meas_valid,
    output logic             in_range,
    output logic             locked,
    output logic             timeout
);

    localparam int GW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);
    localparam logic [GW-1:0]    GOOD_LAST = GW'(LOCK_COUNT - 1);
    // one extra bit so the window bounds never wrap
    localparam logic [CNT_W:0] RANGE_LO =
        (CNT_W+1)'((TOL > HALF_PERIOD) ? 0 : HALF_PERIOD - TOL);
    localparam logic [CNT_W:0] RANGE_HI = (CNT_W+1)'(HALF_PERIOD + TOL);

    blink_state_t     state;
    logic             level_d;
    logic             edge_evt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] meas;
    logic             meas_ok;
    logic             lost;
    logic [GW-1:0]    good_cnt;

    blink_in_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .blink_in   (blink_in),
        .blink_level(blink_level)
    );

    assign edge_evt = blink_level ^ level_d;
    assign meas     = cnt + 1'b1;
    assign meas_ok  = ({1'b0, meas} >= RANGE_LO) && ({1'b0, meas} <= RANGE_HI);
    assign lost     = (state != IDLE) && (cnt == CNT_MAX) && !edge_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            level_d <= blink_level;
            if (edge_evt)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            good_cnt    <= '0;
            half_period <= '0;
            meas_valid  <= 1'b0;
            in_range    <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            if (edge_evt) begin
                if (state != IDLE) begin
                    half_period <= meas;
                    in_range    <= meas_ok;
                    meas_valid  <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        state    <= ACQUIRE;
                        good_cnt <= '0;
                    end
                    ACQUIRE: begin
                        if (!meas_ok) begin
                            good_cnt <= '0;
                        end else if (good_cnt >= GOOD_LAST) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            good_cnt <= good_cnt + 1'b1;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!meas_ok) begin
                            state    <= ACQUIRE;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                    end
                endcase
            end else if (lost) begin
                state    <= IDLE;
                locked   <= 1'b0;
                timeout  <= 1'b1;
                good_cnt <= '0;
            end
        end
    end

endmodule
